// File: rtl/usr_burst_n.sv
// Universal shift register with a command handshake and multi-step bursts.
// One shift/rotate step per clock; busy while a burst runs, done pulses once per completed command.
module usr_burst_n #(
    parameter int              WIDTH   = 8,
    parameter int              CNT_W   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_mode,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] data_in,
    input  logic             sin_left,
    input  logic             sin_right,
    input  logic             abort,
    output logic [WIDTH-1:0] q,
    output logic             sout_left,
    output logic             sout_right,
    output logic             busy,
    output logic             done
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHL  = 3'b001;
    localparam logic [2:0] MODE_SHR  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_RSVD = 3'b111;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [2:0]       mode_q, mode_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             done_q, done_d;
    logic             accept;

    // Single-step transform shared by the accept edge and every RUN edge.
    function automatic logic [WIDTH-1:0] stepValue(
        input logic [2:0]       mode,
        input logic [WIDTH-1:0] cur,
        input logic             sl,
        input logic             sr
    );
        logic [WIDTH-1:0] res;
        case (mode)
            MODE_SHL: res = {cur[WIDTH-2:0], sl};
            MODE_SHR: res = {sr, cur[WIDTH-1:1]};
            MODE_ROL: res = {cur[WIDTH-2:0], cur[WIDTH-1]};
            MODE_ROR: res = {cur[0], cur[WIDTH-1:1]};
            MODE_ASR: res = {cur[WIDTH-1], cur[WIDTH-1:1]};
            default:  res = cur;
        endcase
        return res;
    endfunction

    assign busy       = (state_q == RUN);
    assign cmd_ready  = ~busy;
    assign accept     = cmd_valid && cmd_ready;
    assign q          = data_q;
    assign done       = done_q;
    assign sout_left  = data_q[WIDTH-1];
    assign sout_right = data_q[0];

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        mode_d      = mode_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;

        if (state_q == IDLE) begin
            if (accept) begin
                if (cmd_mode == MODE_LOAD) begin
                    data_d = data_in;
                    done_d = 1'b1;
                end else if (cmd_mode == MODE_HOLD || cmd_mode == MODE_RSVD ||
                             cmd_count == '0) begin
                    done_d = 1'b1;
                end else if (cmd_count == CNT_W'(1)) begin
                    data_d = stepValue(cmd_mode, data_q, sin_left, sin_right);
                    done_d = 1'b1;
                end else begin
                    data_d      = stepValue(cmd_mode, data_q, sin_left, sin_right);
                    mode_d      = cmd_mode;
                    remaining_d = cmd_count - CNT_W'(1);
                    state_d     = RUN;
                end
            end
        end else begin
            // Abort takes priority over the step and never produces a done pulse.
            if (abort) begin
                state_d     = IDLE;
                remaining_d = '0;
            end else begin
                data_d      = stepValue(mode_q, data_q, sin_left, sin_right);
                remaining_d = remaining_q - CNT_W'(1);
                if (remaining_q == CNT_W'(1)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            data_q      <= RST_VAL;
            mode_q      <= MODE_HOLD;
            remaining_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            mode_q      <= mode_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_usr_burst_n.sv
// Directed bench for usr_burst_n: per-cycle expectations are queued as stimulus is driven
// and popped one entry per clock edge for comparison.
module tb_usr_burst_n;

    logic       clk;
    logic       rst;
    logic       cmdValid;
    logic       cmdReady;
    logic [2:0] cmdMode;
    logic [3:0] cmdCount;
    logic [7:0] dataIn;
    logic       sinLeft;
    logic       sinRight;
    logic       abortIn;
    logic [7:0] qOut;
    logic       soutLeft;
    logic       soutRight;
    logic       busyOut;
    logic       doneOut;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] q;
        logic       busy;
        logic       done;
        logic       ready;
    } exp_t;

    exp_t expQ[$];

    usr_burst_n #(.WIDTH(8), .CNT_W(4), .RST_VAL(8'h00)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmdValid),
        .cmd_ready  (cmdReady),
        .cmd_mode   (cmdMode),
        .cmd_count  (cmdCount),
        .data_in    (dataIn),
        .sin_left   (sinLeft),
        .sin_right  (sinRight),
        .abort      (abortIn),
        .q          (qOut),
        .sout_left  (soutLeft),
        .sout_right (soutRight),
        .busy       (busyOut),
        .done       (doneOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string tag, input string field,
                       input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
        end
    endtask

    task automatic pushExp(input logic [7:0] q, input logic busy, input logic done);
        exp_t e;
        e.q     = q;
        e.busy  = busy;
        e.done  = done;
        e.ready = ~busy;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic valid, input logic [2:0] mode,
                                 input logic [3:0] count, input logic [7:0] data,
                                 input logic sl, input logic sr, input logic ab);
        cmdValid = valid;
        cmdMode  = mode;
        cmdCount = count;
        dataIn   = data;
        sinLeft  = sl;
        sinRight = sr;
        abortIn  = ab;
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        checks++;
        assert (expQ.size() != 0) else begin
            failures++;
            $error("[TB] FAIL %s scoreboard observed=empty expected=entry", tag);
        end
        if (expQ.size() != 0) begin
            e = expQ.pop_front();
            cmp(tag, "q",     qOut,                 e.q);
            cmp(tag, "busy",  {7'd0, busyOut},      {7'd0, e.busy});
            cmp(tag, "done",  {7'd0, doneOut},      {7'd0, e.done});
            cmp(tag, "ready", {7'd0, cmdReady},     {7'd0, e.ready});
            cmp(tag, "sout",  {6'd0, soutLeft, soutRight}, {6'd0, e.q[7], e.q[0]});
        end
    endtask

    initial begin
        $display("[TB] starting usr_burst_n bench");
        rst = 1'b1;
        applyStimulus(1'b0, 3'b000, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        cmp("reset", "q",    qOut,             8'h00);
        cmp("reset", "busy", {7'd0, busyOut},  8'h00);
        cmp("reset", "done", {7'd0, doneOut},  8'h00);
        rst = 1'b0;

        // LOAD 0xA5: done for exactly one cycle, never busy
        applyStimulus(1'b1, 3'b011, 4'd0, 8'hA5, 1'b0, 1'b0, 1'b0);
        pushExp(8'hA5, 1'b0, 1'b1); checkOutput("load_a5");
        applyStimulus(1'b0, 3'b000, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        pushExp(8'hA5, 1'b0, 1'b0); checkOutput("load_a5_idle");

        // ROL x3
        applyStimulus(1'b1, 3'b100, 4'd3, 8'h00, 1'b0, 1'b0, 1'b0);
        pushExp(8'h4B, 1'b1, 1'b0); checkOutput("rol_1");
        applyStimulus(1'b0, 3'b000, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        pushExp(8'h96, 1'b1, 1'b0); checkOutput("rol_2");
        pushExp(8'h2D, 1'b0, 1'b1); checkOutput("rol_3");
        pushExp(8'h2D, 1'b0, 1'b0); checkOutput("rol_idle");

        // LOAD 0x96 then back-to-back ASR x2, then SHL count=0 in the done cycle
        applyStimulus(1'b1, 3'b011, 4'd0, 8'h96, 1'b0, 1'b0, 1'b0);
        pushExp(8'h96, 1'b0, 1'b1); checkOutput("load_96");
        applyStimulus(1'b1, 3'b110, 4'd2, 8'h00, 1'b0, 1'b0, 1'b0);
        pushExp(8'hCB, 1'b1, 1'b0); checkOutput("asr_1");
        applyStimulus(1'b0, 3'b000, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        pushExp(8'hE5, 1'b0, 1'b1); checkOutput("asr_2");
        applyStimulus(1'b1, 3'b001, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0);
        pushExp(8'hE5, 1'b0, 1'b1); checkOutput("shl_cnt0");
        applyStimulus(1'b0, 3'b000, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        pushExp(8'hE5, 1'b0, 1'b0); checkOutput("shl_cnt0_idle");

        // SHL x4 with sin_left=1; a LOAD held on cmd_valid while busy must be ignored
        applyStimulus(1'b1, 3'b011, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        pushExp(8'h00, 1'b0, 1'b1); checkOutput("load_00");
        applyStimulus(1'b1, 3'b001, 4'd4, 8'h00, 1'b1, 1'b0, 1'b0);
        pushExp(8'h01, 1'b1, 1'b0); checkOutput("shl_1");
        applyStimulus(1'b1, 3'b011, 4'd9, 8'hFF, 1'b1, 1'b0, 1'b0);
        pushExp(8'h03, 1'b1, 1'b0); checkOutput("shl_2");
        pushExp(8'h07, 1'b1, 1'b0); checkOutput("shl_3");
        pushExp(8'h0F, 1'b0, 1'b1); checkOutput("shl_4");
        applyStimulus(1'b0, 3'b000, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        pushExp(8'h0F, 1'b0, 1'b0); checkOutput("shl_idle");

        // LOAD 0xF0 then SHR x5 with abort at the third edge
        applyStimulus(1'b1, 3'b011, 4'd0, 8'hF0, 1'b0, 1'b0, 1'b0);
        pushExp(8'hF0, 1'b0, 1'b1); checkOutput("load_f0");
        applyStimulus(1'b1, 3'b010, 4'd5, 8'h00, 1'b0, 1'b0, 1'b0);
        pushExp(8'h78, 1'b1, 1'b0); checkOutput("shr_1");
        applyStimulus(1'b0, 3'b000, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        pushExp(8'h3C, 1'b1, 1'b0); checkOutput("shr_2");
        applyStimulus(1'b0, 3'b000, 4'd0, 8'h00, 1'b0, 1'b0, 1'b1);
        pushExp(8'h3C, 1'b0, 1'b0); checkOutput("shr_abort");
        applyStimulus(1'b0, 3'b000, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        pushExp(8'h3C, 1'b0, 1'b0); checkOutput("abort_idle");

        // Abort coinciding with an accept in IDLE: the accept wins
        applyStimulus(1'b1, 3'b011, 4'd0, 8'h81, 1'b0, 1'b0, 1'b1);
        pushExp(8'h81, 1'b0, 1'b1); checkOutput("abort_vs_load");

        // ROR x1 from 0x81 completes in a single edge
        applyStimulus(1'b1, 3'b101, 4'd1, 8'h00, 1'b0, 1'b0, 1'b0);
        pushExp(8'hC0, 1'b0, 1'b1); checkOutput("ror_1");

        // SHL x7 interrupted by an asynchronous reset mid-burst
        applyStimulus(1'b1, 3'b001, 4'd7, 8'h00, 1'b0, 1'b0, 1'b0);
        pushExp(8'h80, 1'b1, 1'b0); checkOutput("shl7_1");
        applyStimulus(1'b0, 3'b000, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        pushExp(8'h00, 1'b1, 1'b0); checkOutput("shl7_2");
        #3;
        rst = 1'b1;
        #1;
        cmp("async_rst", "q",    qOut,             8'h00);
        cmp("async_rst", "busy", {7'd0, busyOut},  8'h00);
        cmp("async_rst", "done", {7'd0, doneOut},  8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // LOAD 0x5A then reserved mode 111 with count=7: q unchanged, one done pulse
        applyStimulus(1'b1, 3'b011, 4'd0, 8'h5A, 1'b0, 1'b0, 1'b0);
        pushExp(8'h5A, 1'b0, 1'b1); checkOutput("load_5a");
        applyStimulus(1'b1, 3'b111, 4'd7, 8'h00, 1'b1, 1'b1, 1'b0);
        pushExp(8'h5A, 1'b0, 1'b1); checkOutput("rsvd_7");
        applyStimulus(1'b0, 3'b000, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        pushExp(8'h5A, 1'b0, 1'b0); checkOutput("rsvd_idle");
        pushExp(8'h5A, 1'b0, 1'b0); checkOutput("final_idle");

        checks++;
        assert (expQ.size() == 0) else begin
            failures++;
            $error("[TB] FAIL scoreboard_drain observed=%0d expected=0", expQ.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
